// File: rtl/psum_writeback_pkg.sv
// Shared types and helpers for the partial-sum writeback stage.
package psum_writeback_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_V,
        LAT,
        WR,
        DONE
    } state_t;

    localparam int DATA_LAT_DEF = 2;

    // Saturation bounds of a w-bit two's-complement value.
    function automatic longint sat_hi(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/psum_writeback_lane.sv
// One lane of the writeback datapath: sign-extend, optional accumulate,
// saturate to PSUM_BW, optional ReLU.
module psum_lane
    import psum_writeback_pkg::*;
#(
    parameter int BW      = 16,
    parameter int PSUM_BW = 16
) (
    input  logic [BW-1:0]      fifo_lane,
    input  logic [PSUM_BW-1:0] sram_lane,
    input  logic               acc,
    input  logic               relu,
    output logic [PSUM_BW-1:0] result
);

    // One guard bit is enough: both addends fit in PSUM_BW bits.
    localparam int SW = PSUM_BW + 1;
    localparam logic signed [SW-1:0] HI = SW'(sat_hi(PSUM_BW));
    localparam logic signed [SW-1:0] LO = SW'(sat_lo(PSUM_BW));

    logic signed [SW-1:0] ext;
    logic signed [SW-1:0] addend;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] sat;

    always_comb begin
        ext    = SW'(signed'(fifo_lane));
        addend = acc ? SW'(signed'(sram_lane)) : '0;
        sum    = ext + addend;
        if (sum > HI) begin
            sat = HI;
        end else if (sum < LO) begin
            sat = LO;
        end else begin
            sat = sum;
        end
        if (relu && sat[SW-1]) begin
            sat = '0;
        end
        result = sat[PSUM_BW-1:0];
    end

endmodule

// File: rtl/psum_writeback.sv
// Drains rows from the output FIFO into the partial-sum SRAM, either
// overwriting or accumulating each lane, one row per DATA_LAT+2 cycles.
module psum_writeback
    import psum_writeback_pkg::*;
#(
    parameter int COL      = 8,
    parameter int BW       = 16,
    parameter int PSUM_BW  = 16,
    parameter int ADDR_W   = 11,
    parameter int DATA_LAT = DATA_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_W:0]        num_rows,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   acc,
    input  logic                   relu,
    input  logic                   ofifo_valid,
    output logic                   ofifo_rd,
    input  logic [COL*BW-1:0]      ofifo_out,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [COL*PSUM_BW-1:0] sram_d,
    input  logic [COL*PSUM_BW-1:0] sram_q,
    output logic                   busy,
    output logic                   done
);

    localparam int LAT_W = (DATA_LAT > 1) ? $clog2(DATA_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(DATA_LAT - 1);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [ADDR_W:0]  ROW_ONE  = 1;
    localparam logic [ADDR_W:0]  MAX_ROWS = {1'b1, {ADDR_W{1'b0}}};

    state_t                 state_reg, state_next;
    logic [ADDR_W:0]        num_rows_reg, num_rows_next;
    logic [ADDR_W:0]        row_reg, row_next;
    logic [ADDR_W-1:0]      base_reg, base_next;
    logic                   acc_reg, acc_next;
    logic                   relu_reg, relu_next;
    logic [LAT_W-1:0]       lat_reg, lat_next;
    logic                   q_pend_reg, q_pend_next;
    logic [COL*BW-1:0]      fifo_cap_reg, fifo_cap_next;
    logic [COL*PSUM_BW-1:0] q_cap_reg, q_cap_next;
    logic                   done_reg;
    logic [COL*PSUM_BW-1:0] lane_res;
    logic [ADDR_W-1:0]      row_addr;

    assign row_addr  = base_reg + row_reg[ADDR_W-1:0];
    assign sram_addr = row_addr;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;

    genvar gi;
    generate
        for (gi = 0; gi < COL; gi++) begin : g_lane
            psum_lane #(
                .BW      (BW),
                .PSUM_BW (PSUM_BW)
            ) u_lane (
                .fifo_lane (fifo_cap_reg[gi*BW +: BW]),
                .sram_lane (q_cap_reg[gi*PSUM_BW +: PSUM_BW]),
                .acc       (acc_reg),
                .relu      (relu_reg),
                .result    (lane_res[gi*PSUM_BW +: PSUM_BW])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            num_rows_reg <= '0;
            row_reg      <= '0;
            base_reg     <= '0;
            acc_reg      <= 1'b0;
            relu_reg     <= 1'b0;
            lat_reg      <= '0;
            q_pend_reg   <= 1'b0;
            fifo_cap_reg <= '0;
            q_cap_reg    <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            num_rows_reg <= num_rows_next;
            row_reg      <= row_next;
            base_reg     <= base_next;
            acc_reg      <= acc_next;
            relu_reg     <= relu_next;
            lat_reg      <= lat_next;
            q_pend_reg   <= q_pend_next;
            fifo_cap_reg <= fifo_cap_next;
            q_cap_reg    <= q_cap_next;
            done_reg     <= (state_reg == DONE);
        end
    end

    always_comb begin
        state_next    = state_reg;
        num_rows_next = num_rows_reg;
        row_next      = row_reg;
        base_next     = base_reg;
        acc_next      = acc_reg;
        relu_next     = relu_reg;
        lat_next      = lat_reg;
        q_pend_next   = q_pend_reg;
        fifo_cap_next = fifo_cap_reg;
        q_cap_next    = q_cap_reg;
        ofifo_rd      = 1'b0;
        sram_cen      = 1'b1;
        sram_wen      = 1'b1;
        sram_d        = '0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    num_rows_next = num_rows;
                    base_next     = base_addr;
                    acc_next      = acc;
                    relu_next     = relu;
                    row_next      = '0;
                    q_pend_next   = 1'b0;
                    state_next    = (num_rows == '0) ? DONE : WAIT_V;
                end
            end
            WAIT_V: begin
                if (ofifo_valid) begin
                    ofifo_rd    = 1'b1;
                    sram_cen    = ~acc_reg;
                    q_pend_next = acc_reg;
                    lat_next    = LAT_LOAD;
                    state_next  = LAT;
                end
            end
            LAT: begin
                // SRAM data lands on the first LAT cycle; FIFO data on the last.
                if (q_pend_reg) begin
                    q_cap_next  = sram_q;
                    q_pend_next = 1'b0;
                end
                if (lat_reg == '0) begin
                    fifo_cap_next = ofifo_out;
                    state_next    = WR;
                end else begin
                    lat_next = lat_reg - LAT_ONE;
                end
            end
            WR: begin
                sram_cen   = 1'b0;
                sram_wen   = 1'b0;
                sram_d     = lane_res;
                row_next   = row_reg + ROW_ONE;
                state_next = (row_next == num_rows_reg) ? DONE : WAIT_V;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    a_num_rows_legal: assert property (
        @(posedge clk) disable iff (!reset)
        (state_reg == IDLE && start) |-> (num_rows <= MAX_ROWS)
    );

endmodule

// File: tb/tb_psum_writeback.sv
// Directed bench for psum_writeback with behavioural FIFO and SRAM models.
module tb_psum_writeback;

    localparam int COL     = 8;
    localparam int BW      = 16;
    localparam int PSUM_BW = 16;
    localparam int ADDR_W  = 11;
    localparam int DW      = COL * PSUM_BW;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [ADDR_W:0]        num_rows;
    logic [ADDR_W-1:0]      base_addr;
    logic                   acc_in;
    logic                   relu_in;
    logic                   ofifo_valid;
    logic                   ofifo_rd;
    logic [COL*BW-1:0]      ofifo_out;
    logic                   sram_cen;
    logic                   sram_wen;
    logic [ADDR_W-1:0]      sram_addr;
    logic [DW-1:0]          sram_d;
    logic [DW-1:0]          sram_q;
    logic                   busy;
    logic                   done;

    psum_writeback #(
        .COL      (COL),
        .BW       (BW),
        .PSUM_BW  (PSUM_BW),
        .ADDR_W   (ADDR_W),
        .DATA_LAT (2)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .num_rows    (num_rows),
        .base_addr   (base_addr),
        .acc         (acc_in),
        .relu        (relu_in),
        .ofifo_valid (ofifo_valid),
        .ofifo_rd    (ofifo_rd),
        .ofifo_out   (ofifo_out),
        .sram_cen    (sram_cen),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_d      (sram_d),
        .sram_q      (sram_q),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // FIFO model: rows pushed by the stimulus, popped by ofifo_rd, two-cycle data latency.
    logic [DW-1:0] tb_rows [0:63];
    int            tb_wr = 0;
    int            fifo_ptr = 0;
    logic [DW-1:0] pipe1;

    always @(posedge clk) begin
        if (ofifo_rd) begin
            pipe1    <= tb_rows[fifo_ptr];
            fifo_ptr <= fifo_ptr + 1;
        end
        ofifo_out <= pipe1;
    end

    // SRAM model with one-cycle read latency and a preload port.
    logic [DW-1:0]     mem [0:(1<<ADDR_W)-1];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [DW-1:0]     pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (!sram_cen) begin
            if (!sram_wen) mem[sram_addr] <= sram_d;
            else           sram_q <= mem[sram_addr];
        end
    end

    // Bus monitor, sampled mid-cycle.
    int                cyc = 0;
    int                cen_cnt = 0;
    int                done_cnt = 0;
    int                rd_b2b = 0;
    logic              prev_rd = 1'b0;
    logic              last_rd = 1'b0;
    logic [ADDR_W-1:0] last_rd_addr = '0;
    int                rd_cyc [$];
    logic [ADDR_W-1:0] rd_addr_q [$];
    logic [ADDR_W-1:0] wr_addr_q [$];
    logic [DW-1:0]     wr_data_q [$];
    logic              wr_pre_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ofifo_rd) begin
            if (prev_rd) rd_b2b <= rd_b2b + 1;
            rd_cyc.push_back(cyc);
        end
        prev_rd <= ofifo_rd;
        if (!sram_cen) begin
            cen_cnt <= cen_cnt + 1;
            if (sram_wen) begin
                rd_addr_q.push_back(sram_addr);
                last_rd      <= 1'b1;
                last_rd_addr <= sram_addr;
                $display("t=%0t sram read  addr=%h", $time, sram_addr);
            end else begin
                wr_addr_q.push_back(sram_addr);
                wr_data_q.push_back(sram_d);
                wr_pre_q.push_back(last_rd && (last_rd_addr == sram_addr));
                last_rd <= 1'b0;
                $display("t=%0t sram write addr=%h data=%h", $time, sram_addr, sram_d);
            end
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_row(input int l0, input int l1);
        logic [DW-1:0] r;
        r        = '0;
        r[15:0]  = l0[15:0];
        r[31:16] = l1[15:0];
        return r;
    endfunction

    task automatic push_row(input int l0, input int l1);
        tb_rows[tb_wr] = mk_row(l0, l1);
        tb_wr++;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        pl_addr = ADDR_W'(a);
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic start_pass(input int n, input int b, input logic a, input logic r);
        @(negedge clk);
        num_rows  = (ADDR_W+1)'(n);
        base_addr = ADDR_W'(b);
        acc_in    = a;
        relu_in   = r;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_val({tag, "_done"}, done_cnt - d0, 1);
    endtask

    task automatic check_wr(input string tag, input int idx, input int ea, input logic [DW-1:0] ed);
        if (idx < wr_addr_q.size()) begin
            check_val({tag, "_addr"}, wr_addr_q[idx], ea);
            check_val({tag, "_data"}, wr_data_q[idx], ed);
        end else begin
            check_val({tag, "_missing"}, 0, 1);
        end
    endtask

    initial begin
        int w0, r0, q0, d0, c0;
        int l0s [3] = '{5, -3, 7};
        logic found;

        rst_n = 1'b0; start = 1'b0; num_rows = '0; base_addr = '0;
        acc_in = 1'b0; relu_in = 1'b0; ofifo_valid = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (3) @(negedge clk);
        check_val("rst_rd", ofifo_rd, 0);
        check_val("rst_cen", sram_cen, 1);
        check_val("rst_wen", sram_wen, 1);
        check_val("rst_addr", sram_addr, 0);
        check_val("rst_d", sram_d, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Overwrite, three rows at 0x10.
        for (int i = 0; i < 3; i++) push_row(l0s[i], 101 + i);
        ofifo_valid = 1'b1;
        w0 = wr_addr_q.size(); r0 = rd_cyc.size(); q0 = rd_addr_q.size(); d0 = done_cnt;
        start_pass(3, 'h010, 1'b0, 1'b0);
        wait_done("ovw", d0);
        check_val("ovw_writes", wr_addr_q.size() - w0, 3);
        for (int i = 0; i < 3; i++) check_wr("ovw_row", w0 + i, 'h10 + i, mk_row(l0s[i], 101 + i));
        check_val("ovw_rd_cnt", rd_cyc.size() - r0, 3);
        for (int i = 1; i < 3; i++) begin
            if (r0 + i < rd_cyc.size()) check_val("ovw_rd_gap", rd_cyc[r0+i] - rd_cyc[r0+i-1], 4);
            else                        check_val("ovw_rd_gap_missing", 0, 1);
        end
        check_val("ovw_sram_reads", rd_addr_q.size() - q0, 0);
        ofifo_valid = 1'b0;

        // Accumulate with saturation in both directions.
        preload('h20, mk_row(32760, -32760));
        push_row(100, -100);
        ofifo_valid = 1'b1;
        w0 = wr_addr_q.size(); q0 = rd_addr_q.size(); d0 = done_cnt;
        start_pass(1, 'h020, 1'b1, 1'b0);
        wait_done("sat", d0);
        check_wr("sat_row", w0, 'h20, mk_row(32767, -32768));
        check_val("sat_reads", rd_addr_q.size() - q0, 1);
        if (q0 < rd_addr_q.size()) check_val("sat_rd_addr", rd_addr_q[q0], 'h20);
        if (w0 < wr_pre_q.size())  check_val("sat_rd_before_wr", wr_pre_q[w0], 1);
        ofifo_valid = 1'b0;

        // Accumulate with ReLU: -50+20 clamps to 0, -50+80 gives 30.
        preload('h30, mk_row(-50, -50));
        preload('h31, mk_row(-50, -50));
        push_row(20, 80);
        push_row(80, 20);
        ofifo_valid = 1'b1;
        w0 = wr_addr_q.size(); d0 = done_cnt;
        start_pass(2, 'h030, 1'b1, 1'b1);
        wait_done("relu", d0);
        check_wr("relu_row0", w0, 'h30, mk_row(0, 30));
        check_wr("relu_row1", w0 + 1, 'h31, mk_row(30, 0));
        if (w0 + 1 < wr_pre_q.size()) check_val("relu_rd_before_wr", wr_pre_q[w0+1], 1);
        ofifo_valid = 1'b0;

        // Stall: drop ofifo_valid for 10 cycles after the first write.
        push_row(11, 12);
        push_row(13, 14);
        ofifo_valid = 1'b1;
        w0 = wr_addr_q.size(); d0 = done_cnt;
        start_pass(2, 'h040, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (!sram_cen && !sram_wen) found = 1'b1;
            else @(negedge clk);
        end
        check_val("stall_wr_seen", found, 1);
        ofifo_valid = 1'b0;
        @(negedge clk);
        r0 = rd_cyc.size(); c0 = cen_cnt;
        repeat (10) @(negedge clk);
        check_val("stall_rd", rd_cyc.size() - r0, 0);
        check_val("stall_cen", cen_cnt - c0, 0);
        check_val("stall_busy", busy, 1);
        ofifo_valid = 1'b1;
        wait_done("stall", d0);
        check_wr("stall_row0", w0, 'h40, mk_row(11, 12));
        check_wr("stall_row1", w0 + 1, 'h41, mk_row(13, 14));
        ofifo_valid = 1'b0;

        // Zero rows: done two cycles after start, no SRAM or FIFO traffic.
        r0 = rd_cyc.size(); c0 = cen_cnt;
        @(negedge clk);
        num_rows = '0; base_addr = 'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("zero_busy_c1", busy, 1);
        check_val("zero_done_c1", done, 0);
        @(negedge clk);
        check_val("zero_done_c2", done, 1);
        check_val("zero_busy_c2", busy, 0);
        @(negedge clk);
        check_val("zero_done_c3", done, 0);
        check_val("zero_cen", cen_cnt - c0, 0);
        check_val("zero_rd", rd_cyc.size() - r0, 0);

        // Address wrap from 0x7FF to 0x000.
        push_row(1, 2);
        push_row(3, 4);
        ofifo_valid = 1'b1;
        w0 = wr_addr_q.size(); d0 = done_cnt;
        start_pass(2, 'h7FF, 1'b0, 1'b0);
        wait_done("wrap", d0);
        check_wr("wrap_row0", w0, 'h7FF, mk_row(1, 2));
        check_wr("wrap_row1", w0 + 1, 'h000, mk_row(3, 4));
        ofifo_valid = 1'b0;

        // Asynchronous reset during LAT abandons the pass.
        push_row(9, 9);
        ofifo_valid = 1'b1;
        start_pass(2, 'h050, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ofifo_rd) found = 1'b1;
            else @(negedge clk);
        end
        check_val("rst_rd_seen", found, 1);
        @(negedge clk);
        ofifo_valid = 1'b0;
        check_val("rst_busy_pre", busy, 1);
        check_val("rst_addr_pre", sram_addr, 'h50);
        #1 rst_n = 1'b0;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_rd", ofifo_rd, 0);
        check_val("arst_cen", sram_cen, 1);
        check_val("arst_wen", sram_wen, 1);
        check_val("arst_addr", sram_addr, 0);
        check_val("arst_d", sram_d, 0);
        check_val("arst_done", done, 0);
        w0 = wr_addr_q.size(); d0 = done_cnt; r0 = rd_cyc.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_val("arst_no_wr", wr_addr_q.size() - w0, 0);
        check_val("arst_no_done", done_cnt - d0, 0);
        check_val("arst_no_rd", rd_cyc.size() - r0, 0);

        // A start pulse mid-pass must not disturb it.
        push_row(21, 22);
        push_row(23, 24);
        ofifo_valid = 1'b1;
        w0 = wr_addr_q.size(); q0 = rd_addr_q.size(); d0 = done_cnt;
        start_pass(2, 'h060, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        start_pass(5, 'h100, 1'b1, 1'b1);
        wait_done("sbusy", d0);
        check_val("sbusy_writes", wr_addr_q.size() - w0, 2);
        check_wr("sbusy_row0", w0, 'h60, mk_row(21, 22));
        check_wr("sbusy_row1", w0 + 1, 'h61, mk_row(23, 24));
        check_val("sbusy_reads", rd_addr_q.size() - q0, 0);
        repeat (5) @(negedge clk);
        check_val("sbusy_idle", busy, 0);
        ofifo_valid = 1'b0;

        check_val("rd_back_to_back", rd_b2b, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/psum_writeback.md
Name: psum_writeback

Overview:
- Drain stage directly downstream of the output FIFO.
- Pops one column-row at a time while the FIFO reports all columns valid, and writes the row into the partial-sum SRAM.
- Per lane, it either overwrites or accumulates (read-modify-write) with saturation, and can apply ReLU on the final pass.
- A controller kicks off one pass with start; the block reports busy and done.

Parameters:
- COL, 8, number of column lanes per row
- BW, 16, signed width of one lane from the FIFO
- PSUM_BW, 16, signed width of one lane in SRAM; must be >= BW
- ADDR_W, 11, SRAM address width
- DATA_LAT, 2, cycles from the ofifo_rd-high cycle to the cycle ofifo_out is sampled; must be >= 1

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  one-cycle pulse that begins a pass; ignored while busy=1
- num_rows  in  ADDR_W+1  rows in the pass, sampled on start
- base_addr  in  ADDR_W  first SRAM row, sampled on start
- acc  in  1  1 = add to existing SRAM content; sampled on start
- relu  in  1  1 = clamp negatives to 0 before write; sampled on start
- ofifo_valid  in  1  all FIFO columns non-empty
- ofifo_rd  out  1  pop request to FIFO, one cycle per row
- ofifo_out  in  COL*BW  FIFO row data; lane i at [(i+1)*BW-1 : i*BW]
- sram_cen  out  1  SRAM chip enable, active-low
- sram_wen  out  1  SRAM write enable, active-low (1 = read)
- sram_addr  out  ADDR_W  SRAM row address
- sram_d  out  COL*PSUM_BW  SRAM write data
- sram_q  in  COL*PSUM_BW  SRAM read data, valid 1 cycle after a read cycle
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of pass

Behaviour:

Reset (asynchronous assert, synchronous release):
- State = IDLE; ofifo_rd=0, sram_cen=1, sram_wen=1, sram_addr=0, sram_d=0, busy=0, done=0.
- Row counter and latched controls are cleared.
- Reset mid-pass abandons the pass with no further SRAM or FIFO activity and no done pulse.

State machine (IDLE, WAIT_V, LAT, WR, DONE):
- IDLE, start=1:
  - Latch num_rows, base_addr, acc, relu; clear row count.
  - num_rows=0 goes to DONE; otherwise go to WAIT_V.
- WAIT_V:
  - ofifo_valid=0: stall indefinitely with all strobes inactive.
  - ofifo_valid=1: assert ofifo_rd=1 for exactly this cycle.
  - If acc=1, also issue an SRAM read in the same cycle (cen=0, wen=1, addr=base+row).
  - Load the latency counter; go to LAT.
- LAT:
  - Capture sram_q on the cycle after the read.
  - Capture ofifo_out on the DATA_LAT-th cycle after the rd cycle, then go to WR.
  - ofifo_valid is ignored in LAT.
- WR:
  - One write cycle: cen=0, wen=0, addr=base+row, d=computed row.
  - Increment row; if row == num_rows go to DONE, else go to WAIT_V.
- DONE: done=1 for one cycle, busy falls in the same cycle, then go to IDLE.

Timing and strobes:
- Throughput is one row per DATA_LAT+2 cycles when ofifo_valid stays high.
- ofifo_rd is never high on two consecutive cycles.
- ofifo_rd is never high outside WAIT_V.
- sram_cen is high in every cycle that is not a read or write cycle.

Lane arithmetic (every lane identical and independent):
- Sign-extend the BW lane to PSUM_BW.
- If acc=1, add the captured sram_q lane (PSUM_BW signed).
- Saturate the sum to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1].
- If relu=1 and the result is negative, write 0.
- If acc=0, the SRAM lane value is not used and no read is issued.

Addressing:
- sram_addr = (base_addr + row) mod 2^ADDR_W; the address wraps silently.
- num_rows > 2^ADDR_W is illegal; the assertion fires in simulation.

Decomposition:
- Shared package:
  - state enum (IDLE, WAIT_V, LAT, WR, DONE)
  - DATA_LAT default
  - the signed saturation bounds helper
- Sub-module psum_lane: combinational extend / add / saturate / ReLU for one lane, instantiated COL times in a generate loop.

Test Plan:
- Overwrite pass: acc=0, relu=0, base=0x10, 3 rows, ofifo_valid held 1, lane0 values 5, -3, 7.
  - SRAM rows 0x10–0x12 lane0 = 5, -3, 7.
  - Exactly 3 ofifo_rd pulses, spaced 4 cycles apart.
  - One done pulse.
- Accumulate with saturation: SRAM preloaded lane0=32760 and lane1=-32760; FIFO supplies 100 and -100; acc=1.
  - Written lane0=32767, lane1=-32768.
  - Each write is preceded by a read of the same address.
- ReLU: acc=1, relu=1, SRAM=-50, FIFO=20.
  - Writes 0.
  - With SRAM=-50 and FIFO=80, writes 30.
- Stall and boundaries:
  - ofifo_valid dropped for 10 cycles between rows: no ofifo_rd and cen=1 during the gap; resumes correctly.
  - num_rows=0: done pulses 2 cycles after start with no SRAM activity.
  - base=0x7FF with 2 rows: writes to 0x7FF then 0x000.
- Reset and start-while-busy:
  - reset driven low asynchronously mid-LAT: outputs go to reset values immediately; no write or done follows.
  - A start pulse while busy: no effect on the active pass.
